// File: rtl/and_n_drv_pkg.sv
// rtl/and_n_drv_pkg.sv - shared state encoding and limits for the AND-cell pattern driver
package and_n_drv_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } drv_state_e;

  // Two synchronizer stages plus at least one cycle of cell delay.
  localparam int unsigned MIN_SETTLE = 3;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-stage synchronizer, synchronous active-high reset to 0
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/and_n_pattern_driver.sv
// rtl/and_n_pattern_driver.sv - walks all A patterns of an N-input AND cell and checks Z
module and_n_pattern_driver
  import and_n_drv_pkg::*;
#(
  parameter int INPUT_SIZE    = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic [INPUT_SIZE-1:0] A,
  input  logic                  Z,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [CNT_W-1:0]      ERR_CNT,
  output logic [INPUT_SIZE-1:0] FAIL_VEC,
  output logic                  FAIL_VALID
);

  // Shorter holds cannot see the cell output through the synchronizer, so clamp.
  localparam int HOLD = (SETTLE_CYCLES < int'(MIN_SETTLE)) ? int'(MIN_SETTLE) : SETTLE_CYCLES;
  localparam int SW   = $clog2(HOLD);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(HOLD - 1);

  drv_state_e    state_q, state_d;
  logic [SW-1:0] settle_cnt;
  logic          z_s;
  logic          expected;
  logic          mismatch;
  logic          err_sat;

  sync_2ff u_sync_z (
    .CLK (CLK),
    .RST (RST),
    .d   (Z),
    .q   (z_s)
  );

  // A doubles as the pattern register; the run stops at all ones so it never wraps.
  assign expected = &A;
  assign mismatch = (z_s != expected);
  assign err_sat  = &ERR_CNT;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (START) state_d = S_SETTLE;
      S_SETTLE:       if (settle_cnt == '0) state_d = S_SAMPLE;
      S_SAMPLE:       state_d = expected ? S_DONE : S_SETTLE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      A          <= '0;
      settle_cnt <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_CNT    <= '0;
      FAIL_VEC   <= '0;
      FAIL_VALID <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            A          <= '0;
            settle_cnt <= SETTLE_LOAD;
            ERR_CNT    <= '0;
            FAIL_VEC   <= '0;
            FAIL_VALID <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            BUSY       <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        S_SAMPLE: begin
          if (mismatch) begin
            if (!err_sat) ERR_CNT <= ERR_CNT + 1'b1;
            if (!FAIL_VALID) begin
              FAIL_VEC   <= A;
              FAIL_VALID <= 1'b1;
            end
          end
          if (expected) begin
            BUSY <= 1'b0;
            DONE <= 1'b1;
            PASS <= (ERR_CNT == '0) && !mismatch;
          end else begin
            A          <= A + 1'b1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_and_n_pattern_driver.sv
// tb/tb_and_n_pattern_driver.sv - self-checking bench for and_n_pattern_driver
module tb_and_n_pattern_driver;

  logic        CLK = 1'b0;
  logic        RST, START, START3;
  logic [1:0]  A;
  logic [2:0]  A3;
  logic        Z, Z3;
  logic        BUSY, DONE, PASS, FAIL_VALID;
  logic        BUSY3, DONE3, PASS3, FAIL_VALID3;
  logic [15:0] ERR_CNT;
  logic [1:0]  ERR_CNT3;
  logic [1:0]  FAIL_VEC;
  logic [2:0]  FAIL_VEC3;

  int errors = 0;
  int checks = 0;

  // Z source: 0 = delayed AND, 1 = stuck 0, 2 = stuck 1, 3 = delayed AND xor per-pattern fault
  int         z_mode = 0;
  logic [3:0] flips  = 4'h0;
  logic       z_and  = 1'b0;
  logic       z_flip = 1'b0;

  always #5 CLK = ~CLK;

  always @(A or flips) begin
    #((&A) ? 6 : 4);
    z_and  = &A;
    z_flip = flips[A];
  end

  assign Z = (z_mode == 0) ? z_and :
             (z_mode == 1) ? 1'b0 :
             (z_mode == 2) ? 1'b1 : (z_and ^ z_flip);

  and_n_pattern_driver #(.INPUT_SIZE(2), .SETTLE_CYCLES(8), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .Z(Z), .BUSY(BUSY), .DONE(DONE),
    .PASS(PASS), .ERR_CNT(ERR_CNT), .FAIL_VEC(FAIL_VEC), .FAIL_VALID(FAIL_VALID)
  );

  and_n_pattern_driver #(.INPUT_SIZE(3), .SETTLE_CYCLES(8), .CNT_W(2)) dut3 (
    .CLK(CLK), .RST(RST), .START(START3), .A(A3), .Z(Z3), .BUSY(BUSY3), .DONE(DONE3),
    .PASS(PASS3), .ERR_CNT(ERR_CNT3), .FAIL_VEC(FAIL_VEC3), .FAIL_VALID(FAIL_VALID3)
  );

  // Outcome of a full run from the cell's truth table and the Z fault model.
  function automatic void model_run(input int n, input int mode, input logic [7:0] fl,
                                    input int cw, output int err, output int first,
                                    output bit fv, output bit pass);
    int raw = 0;
    first = 0;
    fv    = 1'b0;
    for (int p = 0; p < (1 << n); p++) begin
      bit want = (p == (1 << n) - 1);
      bit got;
      case (mode)
        1:       got = 1'b0;
        2:       got = 1'b1;
        3:       got = want ^ fl[p];
        default: got = want;
      endcase
      if (got != want) begin
        raw++;
        if (!fv) begin fv = 1'b1; first = p; end
      end
    end
    err  = (raw > (1 << cw) - 1) ? (1 << cw) - 1 : raw;
    pass = (raw == 0);
  endfunction

  // Called #1 after an edge (edge 0); returns #1 after edge 1, which samples START.
  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int from, output int at);
    at = from;
    while (DONE !== 1'b1 && at < 200) begin
      @(posedge CLK); #1;
      at++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; START3 = 1'b0; Z3 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({A, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, FAIL_VALID} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got A=%0d BUSY=%0b DONE=%0b PASS=%0b ERR=%0d FVEC=%0d FV=%0b expected all 0",
               A, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC, FAIL_VALID);
    end
    checks++;
    if ({A3, BUSY3, DONE3, PASS3, ERR_CNT3, FAIL_VEC3, FAIL_VALID3} !== '0) begin
      errors++;
      $display("FAIL reset_outputs3 got A=%0d BUSY=%0b DONE=%0b ERR=%0d expected all 0",
               A3, BUSY3, DONE3, ERR_CNT3);
    end
    RST = 1'b0;
  endtask

  task automatic test_nominal();
    int m_err, m_first; bit m_fv, m_pass;
    z_mode = 0;
    @(posedge CLK); #1;
    pulse_start();
    for (int k = 1; k <= 37; k++) begin
      int exp_a = (k - 1) / 9;
      if (exp_a > 3) exp_a = 3;
      checks++;
      if (A !== 2'(exp_a) || BUSY !== (k < 37) || DONE !== (k == 37)) begin
        errors++;
        $display("FAIL nominal_trace edge=%0d got A=%0d BUSY=%0b DONE=%0b expected A=%0d BUSY=%0b DONE=%0b",
                 k, A, BUSY, DONE, exp_a, k < 37, k == 37);
      end
      if (k < 37) begin @(posedge CLK); #1; end
    end
    model_run(2, 0, 8'h0, 16, m_err, m_first, m_fv, m_pass);
    checks++;
    if (PASS !== m_pass || ERR_CNT !== 16'(m_err) || FAIL_VALID !== m_fv) begin
      errors++;
      $display("FAIL nominal_result got PASS=%0b ERR=%0d FV=%0b expected PASS=%0b ERR=%0d FV=%0b",
               PASS, ERR_CNT, FAIL_VALID, m_pass, m_err, m_fv);
    end
  endtask

  task automatic test_stuck(input int mode);
    int at, m_err, m_first; bit m_fv, m_pass;
    z_mode = mode;
    @(posedge CLK); #1;
    pulse_start();
    wait_done(1, at);
    model_run(2, mode, 8'h0, 16, m_err, m_first, m_fv, m_pass);
    checks++;
    if (at !== 37) begin
      errors++;
      $display("FAIL stuck%0d_done_edge got %0d expected 37", mode, at);
    end
    checks++;
    if (PASS !== m_pass || ERR_CNT !== 16'(m_err) || FAIL_VALID !== m_fv || FAIL_VEC !== 2'(m_first)) begin
      errors++;
      $display("FAIL stuck%0d_result got PASS=%0b ERR=%0d FV=%0b FVEC=%0d expected PASS=%0b ERR=%0d FV=%0b FVEC=%0d",
               mode, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC, m_pass, m_err, m_fv, m_first);
    end
  endtask

  task automatic test_ignore_start_and_reset();
    int at;
    z_mode = 2;
    @(posedge CLK); #1;
    pulse_start();
    repeat (8) begin @(posedge CLK); #1; end
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    checks++;
    if (A !== 2'd1 || BUSY !== 1'b1 || ERR_CNT !== 16'd1) begin
      errors++;
      $display("FAIL busy_start_ignored got A=%0d BUSY=%0b ERR=%0d expected A=1 BUSY=1 ERR=1", A, BUSY, ERR_CNT);
    end
    wait_done(10, at);
    checks++;
    if (at !== 37) begin
      errors++;
      $display("FAIL busy_start_done_edge got %0d expected 37", at);
    end
    pulse_start();
    repeat (13) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++;
    if (A !== 2'd0 || BUSY !== 1'b0 || DONE !== 1'b0 || ERR_CNT !== 16'd0 || FAIL_VALID !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got A=%0d BUSY=%0b DONE=%0b ERR=%0d FV=%0b expected all 0",
               A, BUSY, DONE, ERR_CNT, FAIL_VALID);
    end
    z_mode = 0;
    pulse_start();
    wait_done(1, at);
    checks++;
    if (at !== 37 || PASS !== 1'b1 || ERR_CNT !== 16'd0) begin
      errors++;
      $display("FAIL after_reset_run got edge=%0d PASS=%0b ERR=%0d expected edge=37 PASS=1 ERR=0", at, PASS, ERR_CNT);
    end
  endtask

  task automatic test_back_to_back();
    int at;
    z_mode = 1;
    @(posedge CLK); #1;
    pulse_start();
    wait_done(1, at);
    z_mode = 0;
    pulse_start();
    checks++;
    if (DONE !== 1'b0 || PASS !== 1'b0 || ERR_CNT !== 16'd0 || FAIL_VALID !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear got DONE=%0b PASS=%0b ERR=%0d FV=%0b BUSY=%0b expected 0 0 0 0 1",
               DONE, PASS, ERR_CNT, FAIL_VALID, BUSY);
    end
    wait_done(1, at);
    checks++;
    if (at !== 37 || PASS !== 1'b1 || ERR_CNT !== 16'd0) begin
      errors++;
      $display("FAIL restart_run got edge=%0d PASS=%0b ERR=%0d expected edge=37 PASS=1 ERR=0", at, PASS, ERR_CNT);
    end
  endtask

  task automatic test_saturation();
    int at, m_err, m_first; bit m_fv, m_pass;
    Z3 = 1'b1;
    @(posedge CLK); #1;
    START3 = 1'b1;
    @(posedge CLK); #1;
    START3 = 1'b0;
    at = 1;
    while (DONE3 !== 1'b1 && at < 300) begin @(posedge CLK); #1; at++; end
    model_run(3, 2, 8'h0, 2, m_err, m_first, m_fv, m_pass);
    checks++;
    if (at !== 1 + 8 * 9) begin
      errors++;
      $display("FAIL sat_done_edge got %0d expected %0d", at, 1 + 8 * 9);
    end
    checks++;
    if (ERR_CNT3 !== 2'(m_err) || FAIL_VEC3 !== 3'(m_first) || FAIL_VALID3 !== m_fv || PASS3 !== m_pass) begin
      errors++;
      $display("FAIL sat_result got ERR=%0d FVEC=%0d FV=%0b PASS=%0b expected ERR=%0d FVEC=%0d FV=%0b PASS=%0b",
               ERR_CNT3, FAIL_VEC3, FAIL_VALID3, PASS3, m_err, m_first, m_fv, m_pass);
    end
  endtask

  task automatic test_random_faults();
    int at, m_err, m_first; bit m_fv, m_pass;
    z_mode = 3;
    for (int it = 0; it < 6; it++) begin
      flips = 4'($urandom_range(0, 15));
      @(posedge CLK); #1;
      pulse_start();
      wait_done(1, at);
      model_run(2, 3, {4'h0, flips}, 16, m_err, m_first, m_fv, m_pass);
      checks++;
      if (at !== 37 || PASS !== m_pass || ERR_CNT !== 16'(m_err) || FAIL_VALID !== m_fv ||
          (m_fv && FAIL_VEC !== 2'(m_first))) begin
        errors++;
        $display("FAIL random_faults flips=%h got edge=%0d PASS=%0b ERR=%0d FV=%0b FVEC=%0d expected edge=37 PASS=%0b ERR=%0d FV=%0b FVEC=%0d",
                 flips, at, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC, m_pass, m_err, m_fv, m_first);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stuck(1);
    test_stuck(2);
    test_ignore_start_and_reset();
    test_back_to_back();
    test_saturation();
    test_random_faults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
